clock_set_ctrl: RTL and testbench

Time-set controller that sequences the digital clock counter. Freezes the counter, lets a user step hours/minutes/seconds with three pre-debounced push-button pulses, and commits the edited time with a one-cycle parallel load. Sits between the button front-end and the clock counter; it drives the counter's run enable and load port.

---
 rtl/clock_set_pkg.sv | 15 +
 rtl/clock_set_ctrl_if.sv | 34 +++
 rtl/clock_set_ctrl_field_step.sv | 12 +
 rtl/clock_set_ctrl.sv | 121 ++++++++++++
 tb/tb_clock_set_ctrl.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/clock_set_pkg.sv
// clock_set_pkg: shared states, edit_field encodings, field ranges and widths for the time-set controller.
package clock_set_pkg;
    typedef enum logic [2:0] {RUN, SET_HR, SET_MIN, SET_SEC, COMMIT, ALM_HR, ALM_MIN} state_t;
    localparam logic [2:0] FIELD_NONE    = 3'd0;
    localparam logic [2:0] FIELD_HR      = 3'd1;
    localparam logic [2:0] FIELD_MIN     = 3'd2;
    localparam logic [2:0] FIELD_SEC     = 3'd3;
    localparam logic [2:0] FIELD_ALM_HR  = 3'd4;
    localparam logic [2:0] FIELD_ALM_MIN = 3'd5;
    localparam int HR_MAX = 23;
    localparam int MS_MAX = 59;
    localparam int SEC_W = 6;
    localparam int MIN_W = 6;
    localparam int HR_W = 5;
endpackage

// File: rtl/clock_set_ctrl_if.sv
// clock_set_ctrl_if: button pulses, live time and counter-control bus of the time-set controller.
// CLOCK_SET_ALARM_EN adds the alarm output.
interface clock_set_ctrl_if;
    import clock_set_pkg::*;
    logic btn_mode;
    logic btn_inc;
    logic btn_dec;
    logic [SEC_W-1:0] cur_sec;
    logic [MIN_W-1:0] cur_min;
    logic [HR_W-1:0] cur_hr;
    logic run_en;
    logic load;
    logic [SEC_W-1:0] load_sec;
    logic [MIN_W-1:0] load_min;
    logic [HR_W-1:0] load_hr;
    logic [2:0] edit_field;
`ifdef CLOCK_SET_ALARM_EN
    logic alarm;
`endif
    modport slave (
        input btn_mode, btn_inc, btn_dec, cur_sec, cur_min, cur_hr,
`ifdef CLOCK_SET_ALARM_EN
        output alarm,
`endif
        output run_en, load, load_sec, load_min, load_hr, edit_field
    );
    modport master (
        output btn_mode, btn_inc, btn_dec, cur_sec, cur_min, cur_hr,
`ifdef CLOCK_SET_ALARM_EN
        input alarm,
`endif
        input run_en, load, load_sec, load_min, load_hr, edit_field
    );
endinterface

// File: rtl/clock_set_ctrl_field_step.sv
// field_step: combinational modular increment/decrement; out-of-range values wrap to 0 (up) or MAX (down).
module field_step #(
    parameter int W = 6,
    parameter int MAX = 59
) (
    input  logic [W-1:0] val,
    input  logic         up,
    output logic [W-1:0] nxt
);
    assign nxt = up ? ((val >= W'(MAX)) ? '0 : val + W'(1))
                    : ((val == '0 || val > W'(MAX)) ? W'(MAX) : val - W'(1));
endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: freezes the clock counter, steps hr/min/sec from button pulses and commits with a one-cycle load.
// CLOCK_SET_ALARM_EN adds alarm registers, the ALM_HR/ALM_MIN edit states and the alarm output.
module clock_set_ctrl
    import clock_set_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1000
) (
    input logic clk,
    input logic rst,
    clock_set_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    state_t state, nxt;
    logic [CNT_W-1:0] idle;
    logic [HR_W-1:0] hr, hr_nxt;
    logic [MIN_W-1:0] mn, mn_nxt;
    logic [SEC_W-1:0] sc, sc_nxt;
    logic run_en, load, btn_any, step, timeout;
    logic [2:0] edit_field;

    assign btn_any = bus.btn_mode | bus.btn_inc | bus.btn_dec;
    assign step = (bus.btn_inc ^ bus.btn_dec) & ~bus.btn_mode;
    assign timeout = state != RUN && state != COMMIT && idle == CNT_W'(TIMEOUT_CYC - 1);

    field_step #(.W(HR_W), .MAX(HR_MAX)) u_hr (.val(hr), .up(bus.btn_inc), .nxt(hr_nxt));
    field_step #(.W(MIN_W), .MAX(MS_MAX)) u_min (.val(mn), .up(bus.btn_inc), .nxt(mn_nxt));
    field_step #(.W(SEC_W), .MAX(MS_MAX)) u_sec (.val(sc), .up(bus.btn_inc), .nxt(sc_nxt));

    always_comb begin
        nxt = state;
        edit_field = FIELD_NONE;
        case (state)
            SET_HR: edit_field = FIELD_HR;
            SET_MIN: edit_field = FIELD_MIN;
            SET_SEC: edit_field = FIELD_SEC;
            ALM_HR: edit_field = FIELD_ALM_HR;
            ALM_MIN: edit_field = FIELD_ALM_MIN;
            default: edit_field = FIELD_NONE;
        endcase
        if (timeout)
            nxt = RUN;
        else if (state == COMMIT)
`ifdef CLOCK_SET_ALARM_EN
            nxt = ALM_HR;
`else
            nxt = RUN;
`endif
        else if (bus.btn_mode)
            case (state)
                RUN: nxt = SET_HR;
                SET_HR: nxt = SET_MIN;
                SET_MIN: nxt = SET_SEC;
                SET_SEC: nxt = COMMIT;
                ALM_HR: nxt = ALM_MIN;
                ALM_MIN: nxt = RUN;
                default: nxt = state;
            endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            idle <= '0;
            run_en <= 1'b1;
            load <= 1'b0;
            hr <= '0;
            mn <= '0;
            sc <= '0;
        end else begin
            state <= nxt;
            idle <= (btn_any || nxt != state || state == RUN || state == COMMIT) ? '0 : idle + CNT_W'(1);
            run_en <= nxt inside {RUN, ALM_HR, ALM_MIN};
            load <= nxt == COMMIT;
            if (state == RUN && bus.btn_mode) begin
                hr <= bus.cur_hr;
                mn <= bus.cur_min;
                sc <= bus.cur_sec;
            end else begin
                hr <= (step && state == SET_HR) ? hr_nxt : hr;
                mn <= (step && state == SET_MIN) ? mn_nxt : mn;
                sc <= (step && state == SET_SEC) ? sc_nxt : sc;
            end
        end
    end

    assign bus.run_en = run_en;
    assign bus.load = load;
    assign bus.load_hr = hr;
    assign bus.load_min = mn;
    assign bus.load_sec = sc;
    assign bus.edit_field = edit_field;

`ifdef CLOCK_SET_ALARM_EN
    logic [HR_W-1:0] alm_hr, alm_hr_nxt;
    logic [MIN_W-1:0] alm_min, alm_min_nxt;
    logic silence, sil_nxt, match, alarm;

    field_step #(.W(HR_W), .MAX(HR_MAX)) u_alm_hr (.val(alm_hr), .up(bus.btn_inc), .nxt(alm_hr_nxt));
    field_step #(.W(MIN_W), .MAX(MS_MAX)) u_alm_min (.val(alm_min), .up(bus.btn_inc), .nxt(alm_min_nxt));

    assign match = bus.cur_hr == alm_hr && bus.cur_min == alm_min;
    // silence lives only while the match lasts; using its next value lets btn_dec drop alarm right away
    assign sil_nxt = match & (silence | (state == RUN & bus.btn_dec));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alm_hr <= '0;
            alm_min <= '0;
            silence <= 1'b0;
            alarm <= 1'b0;
        end else begin
            alm_hr <= (step && state == ALM_HR) ? alm_hr_nxt : alm_hr;
            alm_min <= (step && state == ALM_MIN) ? alm_min_nxt : alm_min;
            silence <= sil_nxt;
            alarm <= state == RUN && match && !sil_nxt;
        end
    end

    assign bus.alarm = alarm;
`endif
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed stimulus with a cycle-tagged expectation queue and a load scoreboard checked by a monitor.
module tb_clock_set_ctrl;
    import clock_set_pkg::*;
    localparam int T = 16;
`ifdef CLOCK_SET_ALARM_EN
    localparam bit ALM = 1'b1;
`else
    localparam bit ALM = 1'b0;
`endif
    typedef enum int {K_RUN, K_LOAD, K_EF, K_HR, K_MIN, K_SEC, K_ALM} kind_t;
    typedef struct {int cyc; kind_t k; int v;} exp_t;
    typedef struct {int hr; int mn; int sc;} ld_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int cyc = 0;
    int errors = 0;
    int checks = 0;
    exp_t eq[$];
    ld_t lq[$];

    clock_set_ctrl_if bus();
    clock_set_ctrl #(.TIMEOUT_CYC(T)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic integer actual(kind_t k);
        case (k)
            K_RUN: return integer'(bus.run_en);
            K_LOAD: return integer'(bus.load);
            K_EF: return integer'(bus.edit_field);
            K_HR: return integer'(bus.load_hr);
            K_MIN: return integer'(bus.load_min);
            K_SEC: return integer'(bus.load_sec);
`ifdef CLOCK_SET_ALARM_EN
            K_ALM: return integer'(bus.alarm);
`endif
            default: return -1;
        endcase
    endfunction

    task automatic check(string name, integer act, integer expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, expv);
        end
    endtask

    function automatic void ex(int d, kind_t k, int v);
        eq.push_back('{cyc + d, k, v});
    endfunction

    task automatic drive(bit m, bit i, bit d);
        @(negedge clk);
        bus.btn_mode = m;
        bus.btn_inc = i;
        bus.btn_dec = d;
    endtask

    task automatic quiet(int n);
        repeat (n) begin
            @(negedge clk);
            bus.btn_mode = 0;
            bus.btn_inc = 0;
            bus.btn_dec = 0;
        end
    endtask

    task automatic leave_alarm_edit();
        if (ALM) begin
            drive(1, 0, 0);
            ex(1, K_EF, 5);
            ex(1, K_RUN, 1);
            drive(1, 0, 0);
            ex(1, K_EF, 0);
        end
        quiet(2);
    endtask

    // monitor: due expectations, plus every load strobe against the load scoreboard
    always @(negedge clk) begin
        for (int i = eq.size() - 1; i >= 0; i--)
            if (eq[i].cyc == cyc) begin
                check(eq[i].k.name(), actual(eq[i].k), eq[i].v);
                eq.delete(i);
            end
        if (bus.load === 1'b1) begin
            if (lq.size() == 0)
                check("unexpected_load", 1, 0);
            else begin
                ld_t e;
                e = lq.pop_front();
                check("commit_hr", integer'(bus.load_hr), e.hr);
                check("commit_min", integer'(bus.load_min), e.mn);
                check("commit_sec", integer'(bus.load_sec), e.sc);
                check("commit_run_en", integer'(bus.run_en), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.btn_mode = 0;
        bus.btn_inc = 0;
        bus.btn_dec = 0;
        bus.cur_hr = 12;
        bus.cur_min = 34;
        bus.cur_sec = 56;
        @(negedge clk);
        ex(1, K_RUN, 1); ex(1, K_LOAD, 0); ex(1, K_EF, 0);
        ex(1, K_HR, 0); ex(1, K_MIN, 0); ex(1, K_SEC, 0);
        if (ALM) ex(1, K_ALM, 0);
        quiet(2);
        rst = 1;
        quiet(1);
        // enter edit and full commit path 12:34:56 -> 13:33:57
        drive(1, 0, 0);
        ex(1, K_RUN, 0); ex(1, K_EF, 1); ex(1, K_HR, 12); ex(1, K_MIN, 34); ex(1, K_SEC, 56);
        drive(0, 1, 0); ex(1, K_HR, 13);
        drive(1, 0, 0); ex(1, K_EF, 2);
        drive(0, 0, 1); ex(1, K_MIN, 33);
        drive(1, 0, 0); ex(1, K_EF, 3);
        drive(0, 1, 0); ex(1, K_SEC, 57);
        drive(1, 0, 0);
        lq.push_back('{13, 33, 57});
        ex(1, K_LOAD, 1); ex(1, K_RUN, 0);
        ex(2, K_LOAD, 0); ex(2, K_RUN, 1); ex(2, K_EF, ALM ? 4 : 0);
        quiet(3);
        leave_alarm_edit();
        // wrap boundaries, simultaneous buttons, timeout
        bus.cur_hr = 23; bus.cur_min = 0; bus.cur_sec = 0;
        drive(1, 0, 0); ex(1, K_HR, 23); ex(1, K_MIN, 0);
        drive(0, 1, 0); ex(1, K_HR, 0);
        drive(0, 0, 1); ex(1, K_HR, 23);
        drive(1, 0, 0); ex(1, K_EF, 2);
        drive(0, 0, 1); ex(1, K_MIN, 59);
        drive(0, 1, 0); ex(1, K_MIN, 0);
        drive(0, 1, 1); ex(1, K_MIN, 0); ex(1, K_EF, 2);
        drive(1, 1, 0); ex(1, K_EF, 3); ex(1, K_MIN, 0); ex(1, K_SEC, 0);
        drive(0, 0, 1); ex(1, K_SEC, 59);
        ex(T, K_EF, 3); ex(T, K_RUN, 0);
        ex(T + 1, K_EF, 0); ex(T + 1, K_RUN, 1); ex(T + 1, K_LOAD, 0);
        quiet(T + 3);
        // out-of-range capture is stored as-is, the next step wraps it
        bus.cur_hr = 5; bus.cur_min = 7; bus.cur_sec = 61;
        drive(1, 0, 0); ex(1, K_SEC, 61); ex(1, K_HR, 5);
        drive(1, 0, 0);
        drive(1, 0, 0); ex(1, K_EF, 3);
        drive(0, 1, 0); ex(1, K_SEC, 0);
        drive(1, 0, 0);
        lq.push_back('{5, 7, 0});
        ex(2, K_RUN, 1);
        quiet(2);
        leave_alarm_edit();
        // asynchronous reset in the middle of an edit
        drive(1, 0, 0); ex(1, K_EF, 1);
        quiet(1);
        #2 rst = 0;
        ex(1, K_EF, 0); ex(1, K_RUN, 1); ex(1, K_LOAD, 0); ex(1, K_HR, 0); ex(1, K_SEC, 0);
        quiet(2);
        rst = 1;
        quiet(2);
`ifdef CLOCK_SET_ALARM_EN
        bus.cur_hr = 10; bus.cur_min = 0; bus.cur_sec = 0;
        repeat (4) drive(1, 0, 0);
        lq.push_back('{10, 0, 0});
        ex(2, K_EF, 4);
        quiet(1);
        repeat (7) drive(0, 1, 0);
        leave_alarm_edit();
        ex(1, K_ALM, 0);
        bus.cur_hr = 7; bus.cur_sec = 5;
        ex(1, K_ALM, 1);
        quiet(3);
        drive(0, 0, 1); ex(1, K_ALM, 0); ex(3, K_ALM, 0);
        quiet(4);
        bus.cur_min = 1;
        ex(1, K_ALM, 0);
        quiet(2);
        bus.cur_min = 0;
        ex(1, K_ALM, 1);
        quiet(2);
`endif
        quiet(2);
        foreach (eq[i]) check({"missed_", eq[i].k.name()}, 0, 1);
        foreach (lq[i]) check("missing_load", 0, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
